disp_scan_ctrl: RTL
===================

# disp_scan_ctrl

Time-multiplexed scan controller for a common-segment multi-digit 7-segment display. Holds a DIGITS-nibble display value, cycles through the digits at a programmable slot rate, and presents one 4-bit nibble at a time on `bin_value` for the downstream `led_decoder`. It also drives a one-hot digit-enable bus with inter-digit blanking and optional leading-zero suppression. New values are double-buffered and take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned; must be ≥ 1.
- `TICK_DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, 16: cycles at the start of each slot with all digits disabled; must be < `TICK_DIV`.

Ports:
- `clk` input, 1: single system clock, rising-edge.
- `rst_n` input, 1: reset, asynchronous assert, active-low.
- `load` input, 1: capture `value_in` into the shadow register this cycle.
- `value_in` input, 4*DIGITS: new display value; nibble k (bits 4k+3:4k) is digit k, and digit 0 is least significant.
- `lz_blank` input, 1: leading-zero suppression enable; sampled every cycle.
- `bin_value` output, 4: nibble of the currently scanned digit, fed to the decoder.
- `digit_sel` output, DIGITS: active-high one-hot digit enable; all zero while blanked.
- `frame_done` output, 1: one-cycle pulse when the last slot of a frame ends.

## Operation
- Registers:
  - `slot_cnt`: range 0..TICK_DIV-1.
  - `dig_idx`: range 0..DIGITS-1.
  - `active`, `shadow`: each 4*DIGITS bits.
  - `pending`: 1 bit.
  - `frame_done`: 1 bit.
- Reset values: all registers 0. Resulting output values: `bin_value` = 0, `digit_sel` = 0, `frame_done` = 0.
- Slot counter: increments every cycle. On reaching `TICK_DIV`-1 it wraps to 0, and `dig_idx` advances by 1, wrapping from DIGITS-1 to 0.
- Frame boundary: the cycle in which `slot_cnt` = TICK_DIV-1 and `dig_idx` = DIGITS-1. On the following edge:
  - `frame_done` is set for exactly one cycle.
  - If `pending` = 1, then `active` ← `shadow` and `pending` ← 0.
- Load:
  - When `load` = 1: `shadow` ← `value_in` and `pending` ← 1.
  - A second load before the boundary overwrites `shadow`; the last one wins.
  - A load in the boundary cycle itself does not reach `active` at that boundary. The boundary copies the pre-edge `shadow`, and the new load leaves `pending` = 1 for the next boundary.
- Output functions (Moore: combinational decode of registers only, never of inputs):
  - `bin_value` = `active`[4*dig_idx +: 4]. It changes only on slot advance or on a frame-boundary update.
  - `digit_sel`[dig_idx] = 1 iff `slot_cnt` ≥ BLANK_CYCLES and digit `dig_idx` is not suppressed. All other bits are 0.
- Leading-zero suppression: when `lz_blank` = 1, digit k > 0 is suppressed iff nibbles k..DIGITS-1 of `active` are all zero. Digit 0 is never suppressed. `bin_value` is still driven for suppressed digits.

## Timing
- Slot length is `TICK_DIV` cycles. Frame length is DIGITS*TICK_DIV cycles.
- Enable window: each digit is enabled for `TICK_DIV`-`BLANK_CYCLES` cycles per frame.
- Load latency: a load reaches the display at the first frame boundary strictly after the load cycle. Worst case is DIGITS*TICK_DIV+1 cycles.
- Reset mid-operation: asynchronous. All outputs go to their reset values immediately, and any pending load is discarded. After release, scanning restarts at digit 0, slot count 0.
- Blanking at the slot edge: the cycle in which `dig_idx` changes always has `digit_sel` = 0 (`slot_cnt` = 0 < BLANK_CYCLES when BLANK_CYCLES ≥ 1). With BLANK_CYCLES = 0 there is no blanking.

## Structure
- Shared display package holds:
  - `NIBBLE_W` = 4.
  - The digit-count default.
  - The nibble-slice helper function.
- One sub-module, `scan_tick_gen`: parameterised modulo-`TICK_DIV` counter outputting `slot_cnt` and a wrap strike. All other logic lives in `disp_scan_ctrl`.
- The downstream `led_decoder` is instantiated by the parent, not inside this block.

## Test plan
All scenarios use DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2.
- **Reset:** hold `rst_n`=0, then release → `digit_sel`=0 and `bin_value`=0 for cycles 0–1; `digit_sel`=4'b0001 for cycles 2–7; `digit_sel`=4'b0010 from cycle 10.
- **Load at frame start:** load 16'h4321 at cycle 3 after reset → display stays 0 through the first frame. `frame_done` pulses at cycle 32. In frame 2, `bin_value` = 1, 2, 3, 4 for slots 0–3.
- **Load in boundary cycle:** load A in a mid-frame cycle, then load B in the boundary cycle → the next frame shows A and the following frame shows B.
- **Leading-zero suppression:** `active`=16'h0050 with `lz_blank`=1 → digits 2 and 3 have `digit_sel`=0 for the whole slot; digits 0 and 1 are enabled. `active`=16'h0000 → only digit 0 is enabled.
- **Async reset mid-frame:** assert `rst_n` low mid-frame with `pending`=1, asynchronously → `digit_sel` clears without a clock edge. After release, `active`=0 and the shadow value never appears.

Source files
------------

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment display scan logic.
package disp_scan_ctrl_pkg;

    localparam int NIBBLE_W       = 4;
    localparam int DIGITS_DEFAULT = 4;

    // Widest display the nibble helper can address (16 digits, 4-bit index).
    localparam int MAX_DIGITS     = 16;
    localparam int IDX_MAX_W      = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Return nibble idx of a packed nibble vector (nibble 0 in the low bits).
    function automatic nibble_t nibble_at(
        input logic [NIBBLE_W*MAX_DIGITS-1:0] vec,
        input logic [IDX_MAX_W-1:0]           idx
    );
        return vec[idx*NIBBLE_W +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_tick.sv
// Modulo-TICK_DIV slot counter; strikes wrap in the last cycle of each slot.
module scan_tick_gen #(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] slot_cnt,
    output logic             wrap
);

    logic [CNT_W-1:0] slot_cnt_reg;

    assign wrap     = (slot_cnt_reg == CNT_W'(TICK_DIV - 1));
    assign slot_cnt = slot_cnt_reg;

    // Free-running slot counter, wrapping to 0 after TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_reg <= '0;
        end else if (wrap) begin
            slot_cnt_reg <= '0;
        end else begin
            slot_cnt_reg <= slot_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed digit scanner with frame-synchronous double buffering,
// inter-digit blanking and optional leading-zero suppression.
// DIGITS must be in 1..16 (limited by the shared nibble helper).
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int DIGITS       = DIGITS_DEFAULT,
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [NIBBLE_W*DIGITS-1:0] value_in,
    input  logic                       lz_blank,
    output logic [NIBBLE_W-1:0]        bin_value,
    output logic [DIGITS-1:0]          digit_sel,
    output logic                       frame_done
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VAL_W = NIBBLE_W * DIGITS;

    logic [CNT_W-1:0] slot_cnt;
    logic             wrap;
    logic             frame_end;
    logic             unblanked;

    logic [IDX_W-1:0] dig_idx_reg;
    logic [VAL_W-1:0] active_reg;
    logic [VAL_W-1:0] shadow_reg;
    logic             pending_reg;
    logic             frame_done_reg;
    logic             lz_blank_reg;

    logic [NIBBLE_W*MAX_DIGITS-1:0] active_ext;
    logic [DIGITS-1:0]              suppress;

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .slot_cnt (slot_cnt),
        .wrap     (wrap)
    );

    // Last cycle of the last slot: the only point where the display may change value.
    assign frame_end = wrap && (dig_idx_reg == IDX_W'(DIGITS - 1));

    // Step to the next digit at every slot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_idx_reg <= '0;
        end else if (wrap) begin
            dig_idx_reg <= (dig_idx_reg == IDX_W'(DIGITS - 1)) ? '0 : dig_idx_reg + 1'b1;
        end
    end

    // Shadow capture and frame-boundary promotion; a load landing on the boundary
    // keeps pending set so it is promoted one frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg     <= '0;
            shadow_reg     <= '0;
            pending_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= frame_end;
            if (frame_end && pending_reg) begin
                active_reg <= shadow_reg;
            end
            if (load) begin
                shadow_reg  <= value_in;
                pending_reg <= 1'b1;
            end else if (frame_end) begin
                pending_reg <= 1'b0;
            end
        end
    end

    // Register the suppression enable so outputs depend on state only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lz_blank_reg <= 1'b0;
        end else begin
            lz_blank_reg <= lz_blank;
        end
    end

    assign active_ext = (NIBBLE_W*MAX_DIGITS)'(active_reg);
    assign bin_value  = nibble_at(active_ext, IDX_MAX_W'(dig_idx_reg));
    assign frame_done = frame_done_reg;

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign unblanked = 1'b1;
        end else begin : g_blank
            assign unblanked = (slot_cnt >= CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    // Digit k>0 is a leading zero when it and every higher nibble are zero.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign suppress[gi] = 1'b0;
            end else begin : g_upper
                assign suppress[gi] = lz_blank_reg &&
                                      (active_reg[VAL_W-1 : gi*NIBBLE_W] == '0);
            end
            assign digit_sel[gi] = unblanked && !suppress[gi] &&
                                   (dig_idx_reg == IDX_W'(gi));
        end
    endgenerate

endmodule
